// File: rtl/bin_peak_meter.sv
// bin_peak_meter: serially scans the DFT magnitude bins on each frame strobe and
// converts every magnitude to a log2 level (leading-one position). It keeps a
// per-bin peak level with hold-then-decay ballistics and drives a registered LED
// bar for a window of bins.
module bin_peak_meter #(
  parameter int NBINS      = 120,
  parameter int ND         = 36,
  parameter int LVLW       = 6,
  parameter int DECAY_CYC  = 2500000,
  parameter int HOLD_TICKS = 10,
  parameter int LED_BASE   = 48,
  parameter int NLED       = 10,
  parameter int LED_THRESH = 29
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ND-1:0]   bins_in   [0:NBINS-1],
  input  logic            frame_strobe,
  output logic [LVLW-1:0] level_out [0:NBINS-1],
  output logic [NLED-1:0] led_out,
  output logic            scan_busy,
  output logic            frame_done
);

  localparam int IDXW  = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int TICKW = $clog2(DECAY_CYC);
  localparam int HOLDW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DECAY = 2'd2
  } state_e;

  // Leading-one position plus one; zero magnitude maps to level 0.
  function automatic logic [LVLW-1:0] log2_level(input logic [ND-1:0] m);
    logic [LVLW-1:0] lvl;
    lvl = '0;
    for (int b = 0; b < ND; b++) begin
      if (m[b]) lvl = LVLW'(b + 1);
    end
    return lvl;
  endfunction

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [TICKW-1:0]  tick_q, tick_d;
  logic              tick_wrap;
  logic              frame_pend_q, frame_pend_d;
  logic              decay_pend_q, decay_pend_d;
  logic              scan_last_q, scan_last_d;
  logic              frame_done_q;
  logic              busy_q;
  logic [NLED-1:0]   led_q, led_d;

  logic [LVLW-1:0]   level_q [0:NBINS-1];
  logic [HOLDW-1:0]  hold_q  [0:NBINS-1];

  logic [LVLW-1:0]   cur_level, new_level, level_d;
  logic [HOLDW-1:0]  cur_hold, hold_d;
  logic              bin_we;

  assign cur_level = level_q[idx_q];
  assign cur_hold  = hold_q[idx_q];
  assign new_level = log2_level(bins_in[idx_q]);

  // Next-state logic: tick counter, sticky event flags, pass sequencing and the
  // single per-cycle bin update.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    tick_wrap    = (tick_q == TICKW'(DECAY_CYC - 1));
    tick_d       = tick_wrap ? '0 : tick_q + 1'b1;
    frame_pend_d = frame_pend_q | frame_strobe;
    decay_pend_d = decay_pend_q | tick_wrap;
    scan_last_d  = 1'b0;
    bin_we       = 1'b0;
    level_d      = cur_level;
    hold_d       = cur_hold;

    case (state_q)
      IDLE: begin
        // A frame outranks a decay tick; an event landing in the consuming
        // cycle re-arms its flag rather than being lost.
        if (frame_pend_q) begin
          state_d      = SCAN;
          idx_d        = '0;
          frame_pend_d = frame_strobe;
        end else if (decay_pend_q) begin
          state_d      = DECAY;
          idx_d        = '0;
          decay_pend_d = tick_wrap;
        end
      end

      SCAN: begin
        if (new_level >= cur_level) begin
          bin_we  = 1'b1;
          level_d = new_level;
          hold_d  = HOLDW'(HOLD_TICKS);
        end
        if (idx_q == IDXW'(NBINS - 1)) begin
          state_d     = IDLE;
          scan_last_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DECAY: begin
        bin_we = 1'b1;
        if (cur_hold != '0) begin
          hold_d = cur_hold - 1'b1;
        end else if (cur_level != '0) begin
          level_d = cur_level - 1'b1;
        end
        if (idx_q == IDXW'(NBINS - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control registers: FSM state, scan index, tick counter, pending flags and
  // the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      tick_q       <= '0;
      frame_pend_q <= 1'b0;
      decay_pend_q <= 1'b0;
      scan_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
      frame_pend_q <= frame_pend_d;
      decay_pend_q <= decay_pend_d;
      scan_last_q  <= scan_last_d;
      frame_done_q <= scan_last_q;
      busy_q       <= (state_d != IDLE);
    end
  end

  // Per-bin level/hold storage: at most one bin is rewritten per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is built from flops, not RAM, and is reset because
    // level_out is a direct port that must read zero as soon as rst_n drops.
    if (!rst_n) begin
      for (int i = 0; i < NBINS; i++) begin
        level_q[i] <= '0;
        hold_q[i]  <= '0;
      end
    end else if (bin_we) begin
      level_q[idx_q] <= level_d;
      hold_q[idx_q]  <= hold_d;
    end
  end

  // LED window: threshold compare of the current peak levels.
  always_comb begin
    led_d = '0;
    for (int k = 0; k < NLED; k++) begin
      led_d[NLED-1-k] = (level_q[LED_BASE+k] >= LVLW'(LED_THRESH));
    end
  end

  // Registered LED bar, one cycle behind the levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign level_out  = level_q;
  assign led_out    = led_q;
  assign scan_busy  = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bin_peak_meter.sv
// Testbench for bin_peak_meter: expected frame results are queued when a strobe
// is driven and compared when frame_done arrives; expected decay steps are
// queued when the bins are cleared and compared as bin 48's level changes.
module tb_bin_peak_meter;

  localparam int NBINS      = 120;
  localparam int ND         = 36;
  localparam int LVLW       = 6;
  localparam int DECAY_CYC  = 16;
  localparam int LED_BASE   = 48;
  localparam int NLED       = 10;
  localparam int LED_THRESH = 29;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ND-1:0]   bins_in   [0:NBINS-1];
  logic            frame_strobe = 1'b0;
  logic [LVLW-1:0] level_out [0:NBINS-1];
  logic [NLED-1:0] led_out;
  logic            scan_busy;
  logic            frame_done;

  bin_peak_meter #(.DECAY_CYC(DECAY_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bins_in      (bins_in),
    .frame_strobe (frame_strobe),
    .level_out    (level_out),
    .led_out      (led_out),
    .scan_busy    (scan_busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              done_cyc;
    int              lvl0;
    int              lvl48;
    int              lvl119;
    int              others_nz;
    logic [NLED-1:0] led;
  } exp_t;

  typedef struct {
    int   lvl;
    logic led;
    int   pass;
  } dec_t;

  exp_t sb [$];
  dec_t dq [$];

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int busy_rises = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;
  int   mon_nz;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Bit length of m, i.e. the expected log2 level.
  function automatic int lvl_of(input logic [ND-1:0] m);
    logic [ND-1:0] v;
    int n;
    v = m;
    n = 0;
    while (v != '0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic int count_nonzero();
    int nz;
    nz = 0;
    for (int i = 0; i < NBINS; i++) if (level_out[i] != '0) nz++;
    return nz;
  endfunction

  // Expectation for a scan started from all-zero levels over the current bins.
  task automatic push_expect(input int done_cyc);
    exp_t e;
    int nz;
    nz = 0;
    e.done_cyc = done_cyc;
    e.lvl0     = lvl_of(bins_in[0]);
    e.lvl48    = lvl_of(bins_in[48]);
    e.lvl119   = lvl_of(bins_in[NBINS-1]);
    e.led      = '0;
    for (int k = 0; k < NLED; k++)
      e.led[NLED-1-k] = (lvl_of(bins_in[LED_BASE+k]) >= LED_THRESH);
    for (int i = 1; i < NBINS - 1; i++)
      if (i != 48 && lvl_of(bins_in[i]) != 0) nz++;
    e.others_nz = nz;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_busy && !prev_busy) busy_rises++;
    prev_busy = scan_busy;
  end

  // Scoreboard consumer: one queued expectation per frame_done pulse.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        mon_nz = 0;
        for (int i = 1; i < NBINS - 1; i++)
          if (i != 48 && level_out[i] != '0) mon_nz++;
        check("done_cycle", cyc, mon_e.done_cyc);
        check("level0", level_out[0], mon_e.lvl0);
        check("level48", level_out[48], mon_e.lvl48);
        check("level119", level_out[NBINS-1], mon_e.lvl119);
        check("other_levels_nonzero", mon_nz, mon_e.others_nz);
        check("led_at_done", led_out, mon_e.led);
      end
    end
  end

  task automatic set_bins(input logic [ND-1:0] v);
    for (int i = 0; i < NBINS; i++) bins_in[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_strobe = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_levels_nonzero", count_nonzero(), 0);
    check("rst_led", led_out, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start;
    bit seen;
    start = done_cnt;
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s1;
    int base;
    int start_done;
    int busy_cnt;
    logic [LVLW-1:0] prev48;
    dec_t d;

    set_bins('0);

    // Reset values, then one peak in bin 48 strobed while IDLE.
    do_reset();
    bins_in[48] = 36'h0_8000_0000;
    frame_strobe = 1'b1;
    push_expect(cyc + 1 + 122);
    @(negedge clk);
    frame_strobe = 1'b0;
    wait_done("t2_done_timeout", 300);

    // Hold for 10 ticks, then decay 31, 30, 29 (lit) and 28 (dark).
    bins_in[48] = '0;
    @(negedge clk);
    base = busy_rises;
    dq.push_back('{lvl: 31, led: 1'b1, pass: 11});
    dq.push_back('{lvl: 30, led: 1'b1, pass: 12});
    dq.push_back('{lvl: 29, led: 1'b1, pass: 13});
    dq.push_back('{lvl: 28, led: 1'b0, pass: 14});
    prev48 = level_out[48];
    for (int c = 0; c < 2500 && dq.size() != 0; c++) begin
      @(negedge clk);
      if (level_out[48] != prev48) begin
        d = dq.pop_front();
        prev48 = level_out[48];
        check("decay_level", level_out[48], d.lvl);
        check("decay_pass", busy_rises - base + 1, d.pass);
        @(negedge clk);
        check("decay_led9", led_out[9], d.led);
      end
    end
    check("decay_steps_left", dq.size(), 0);

    // Back-to-back frames: second strobe in scan cycle 5 queues, third drops.
    do_reset();
    set_bins('0);
    bins_in[0] = 36'h0_0000_0001;
    bins_in[NBINS-1] = 36'hF_FFFF_FFFF;
    start_done = done_cnt;
    s1 = cyc + 1;
    frame_strobe = 1'b1;
    push_expect(s1 + 122);
    @(negedge clk);
    frame_strobe = 1'b0;
    repeat (4) @(negedge clk);
    frame_strobe = 1'b1;
    push_expect(s1 + 243);
    @(negedge clk);
    frame_strobe = 1'b0;
    repeat (13) @(negedge clk);
    frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
    repeat (600) @(negedge clk);
    check("t4_done_pulses", done_cnt - start_done, 2);

    // Decay wrap and strobe land in the same IDLE cycle: scan first, all-ones -> 36.
    do_reset();
    set_bins(36'hF_FFFF_FFFF);
    repeat (15) @(negedge clk);
    frame_strobe = 1'b1;
    push_expect(cyc + 1 + 122);
    @(negedge clk);
    frame_strobe = 1'b0;
    wait_done("t5_done_timeout", 300);
    check("t5_decay_follows_scan", scan_busy, 1);
    repeat (130) @(negedge clk);
    check("t5_hold_keeps_level", level_out[5], 36);

    // Reset in the middle of a scan.
    do_reset();
    set_bins('0);
    bins_in[48] = 36'h0_8000_0000;
    start_done = done_cnt;
    frame_strobe = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
    repeat (59) @(negedge clk);
    check("t6_busy_mid_scan", scan_busy, 1);
    check("t6_level48_before_reset", level_out[48], 32);
    #2 rst_n = 1'b0;
    #1;
    check("t6_levels_cleared", count_nonzero(), 0);
    check("t6_led_cleared", led_out, 0);
    check("t6_busy_cleared", scan_busy, 0);
    check("t6_done_cleared", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (scan_busy) busy_cnt++;
    end
    check("t6_idle_after_release", busy_cnt, 0);
    repeat (400) @(negedge clk);
    check("t6_no_frame_done", done_cnt - start_done, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
